// File: rtl/lenet_pkg.sv
// ============================================================================
// Module      : lenet_pkg
// Description : Shared LeNet constants and the one-hot FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lenet_pkg;

    localparam int C_NUM_CLASS = 10;
    localparam int C_DATA_W    = 16;

    typedef logic [3:0] state_t;

    localparam logic [3:0] C_ST_IDLE  = 4'b0001;
    localparam logic [3:0] C_ST_SCAN  = 4'b0010;
    localparam logic [3:0] C_ST_DRAIN = 4'b0100;
    localparam logic [3:0] C_ST_DONE  = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/argmax_cmp.sv
// ============================================================================
// Module      : argmax_cmp
// Description : Registered signed compare-and-update of the running maximum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_cmp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmp_v,
    input  logic [ADDR_W-1:0] cmp_idx,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] best,
    output logic [IDX_W-1:0]  best_idx
);

    logic w_first;
    logic w_greater;

    assign w_first   = (cmp_idx == '0);
    // Strictly greater, so a tie keeps the earlier (lower) index.
    assign w_greater = $signed(rd_data) > $signed(best);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best     <= '0;
            best_idx <= '0;
        end else if (cmp_v && (w_first || w_greater)) begin
            best     <= rd_data;
            best_idx <= IDX_W'(cmp_idx);
        end
    end

endmodule

`default_nettype wire

// File: rtl/lenet_argmax.sv
// ============================================================================
// Module      : lenet_argmax
// Description : Scans the FC3 scores and reports the index of the largest.
//               Optional max_score port enabled by ARGMAX_SCORE_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lenet_argmax
    import lenet_pkg::*;
#(
    parameter int DATA_W    = C_DATA_W,
    parameter int NUM_CLASS = C_NUM_CLASS,
    parameter int ADDR_W    = 4,
    parameter int IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [IDX_W-1:0]  class_idx,
    output logic              valid
`ifdef ARGMAX_SCORE_OUT_EN
    ,
    output logic [DATA_W-1:0] max_score
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_start_q;
    logic              w_trig;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              w_last_issue;
    logic              r_cmp_v;
    logic [ADDR_W-1:0] r_cmp_idx;
    logic [DATA_W-1:0] w_best;
    logic [IDX_W-1:0]  w_best_idx;

    assign w_trig       = start & ~r_start_q;
    assign w_last_issue = (r_rd_addr == ADDR_W'(NUM_CLASS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE:  if (w_trig) w_state_nxt = C_ST_SCAN;
            C_ST_SCAN:  if (w_last_issue) w_state_nxt = C_ST_DRAIN;
            C_ST_DRAIN: if (r_cmp_v && (r_cmp_idx == ADDR_W'(NUM_CLASS - 1)))
                            w_state_nxt = C_ST_DONE;
            C_ST_DONE:  if (w_trig) w_state_nxt = C_ST_SCAN;
            default:    w_state_nxt = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= C_ST_IDLE;
            r_start_q <= 1'b0;
            r_rd_addr <= '0;
            r_cmp_v   <= 1'b0;
            r_cmp_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start;
            r_cmp_v   <= rd_en;
            r_cmp_idx <= r_rd_addr;
            // Issue counter restarts on scan entry and parks on the last address.
            if ((w_state_nxt == C_ST_SCAN) && (r_state != C_ST_SCAN))
                r_rd_addr <= '0;
            else if ((r_state == C_ST_SCAN) && !w_last_issue)
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end
    end

    argmax_cmp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_argmax_cmp (
        .clk      (clk),
        .rst      (rst),
        .cmp_v    (r_cmp_v),
        .cmp_idx  (r_cmp_idx),
        .rd_data  (rd_data),
        .best     (w_best),
        .best_idx (w_best_idx)
    );

    assign rd_en     = (r_state == C_ST_SCAN);
    assign rd_addr   = r_rd_addr;
    assign busy      = (r_state == C_ST_SCAN) || (r_state == C_ST_DRAIN);
    assign valid     = (r_state == C_ST_DONE);
    assign class_idx = valid ? w_best_idx : '0;

`ifdef ARGMAX_SCORE_OUT_EN
    assign max_score = valid ? w_best : '0;
`else
    logic w_unused_best;
    assign w_unused_best = ^w_best;
`endif

endmodule

`default_nettype wire

// File: doc/lenet_argmax.md
# lenet_argmax

Classification stage downstream of the layer sequencer. When the sequencer raises its `finish` level, this block reads the 10 FC3 output scores from the FC3 result buffer and finds the index of the largest signed score. It presents that index as the predicted digit together with a held `valid` level. It occupies the buffer's read port only while it is scanning.

## Interface
- `DATA_W`, 16: width of one FC3 score (two's-complement signed).
- `NUM_CLASS`, 10: number of scores scanned, at addresses 0..NUM_CLASS-1.
- `ADDR_W`, 4: buffer address width; must satisfy 2^ADDR_W ≥ NUM_CLASS.
- `IDX_W`, 4: class index width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  connected to the sequencer's `finish` level. A scan is triggered only by a 0→1 transition.
- `rd_en`  out  1  FC3 buffer read enable.
- `rd_addr`  out  ADDR_W  FC3 buffer read address.
- `rd_data`  in  DATA_W  buffer read data, valid exactly 1 cycle after the `rd_en` cycle.
- `busy`  out  1  scan in progress.
- `class_idx`  out  IDX_W  predicted class.
- `valid`  out  1  `class_idx` holds a completed result.
- `max_score`  out  DATA_W  winning score; present only with `ARGMAX_SCORE_OUT_EN`.

## Operation
- Edge detect: `start_q` register; the trigger is `start & ~start_q`. `start_q` resets to 0, so a `start` already high when reset releases triggers one scan on the first cycle.
- FSM states: IDLE, SCAN, DRAIN, DONE. Encoding is one-hot.
  - IDLE → SCAN on trigger.
  - SCAN → DRAIN after the cycle that issues address NUM_CLASS-1.
  - DRAIN → DONE after the last data word is compared.
  - DONE → SCAN on a new trigger.
  - Otherwise every state holds.
- SCAN:
  - `rd_en`=1.
  - `rd_addr` = issue counter, running 0..NUM_CLASS-1 and incrementing by one per cycle.
- Compare pipeline:
  - `cmp_v` is `rd_en` delayed 1 cycle; `cmp_idx` is `rd_addr` delayed 1 cycle.
  - When `cmp_v`=1: if `cmp_idx`==0, load `best`=`rd_data` and `best_idx`=0.
  - Otherwise, if `$signed(rd_data)` > `$signed(best)` (strictly greater), load `best`=`rd_data` and `best_idx`=`cmp_idx`.
  - Ties therefore keep the lower index.
- DONE: `class_idx`=`best_idx`, `valid`=1. Both are held until the next trigger or `rst`.
- A trigger while in SCAN or DRAIN is ignored; no restart and no queueing.
- On entering SCAN from DONE, `valid` drops to 0 in the same cycle as the first `rd_en`.
- Reset values of all outputs and internal registers are 0: `rd_en`, `rd_addr`, `busy`, `class_idx`, `valid`, `max_score`, `best`, counters and `start_q`. The FSM resets to IDLE.
- `rst` asserted mid-scan aborts the scan immediately (asynchronously), with no partial result.

## Timing
- Trigger sampled at edge E0.
- Cycles 1..NUM_CLASS: `rd_en`=1 with addresses 0..NUM_CLASS-1.
- Cycle NUM_CLASS+1 (DRAIN): last compare.
- `valid`=1 from cycle NUM_CLASS+2, i.e. cycle 12 for the defaults.
- `busy`=1 exactly in cycles 1..NUM_CLASS+1.
- `rd_addr` holds its last value when `rd_en`=0. The buffer must ignore `rd_addr` when `rd_en`=0.
- No combinational path from any input to any output. All outputs are registered or decoded from the state register only.

## Configuration
- `ARGMAX_SCORE_OUT_EN` defined:
  - `max_score` port exists and carries `best` while `valid`=1.
  - `max_score` is 0 while `valid`=0.
- `ARGMAX_SCORE_OUT_EN` undefined:
  - The port is absent.
  - `best` is still kept internally for the compare.
  - Behaviour of all other outputs is identical.

## Structure
- Shared package `lenet_pkg`, holding:
  - `NUM_CLASS` and the `DATA_W` default.
  - The FSM state typedef, in the same one-hot style as the layer sequencer.
- A single sub-module, `argmax_cmp`, is natural: the registered signed compare-and-update of (`best`, `best_idx`), fed by `cmp_v`, `cmp_idx` and `rd_data`.

## Test plan
- Scores {3,-5,7,2,9,0,-1,4,8,1}, `start` 0→1 → `rd_en` high for exactly 10 cycles on addresses 0..9; `valid`=1 at cycle 12; `class_idx`=4; `max_score`=9 (with the macro).
- All scores 0x8000 (most negative) → `class_idx`=0. Scores {1,5,5,…,0} → `class_idx`=1 (tie keeps the lower index).
- Signedness check: scores {0x7FFF at index 9, -1 everywhere else} → `class_idx`=9.
- Assert `rst` at cycle 5 of a scan → all outputs 0 immediately; FSM in IDLE. With `start` still high after release → a full scan restarts and completes with the correct index.
- `start` toggled low→high during SCAN → ignored; exactly 10 reads occur. `start` held high in DONE → no rescan. A later 0→1 on `start` → `valid` drops and a new scan gives the new result.
